// File: rtl/err_metric_accum.sv
// Error-metric accumulator for exact/approximate multiplier sweeps.
// Each accepted (exact, apprx) pair passes through a two-stage pipeline:
// stage 1 forms the signed and absolute error distance, and stage 2 folds
// those values into the run totals. Software derives ER/MED/MNED/MRED from
// the final totals.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | after reset, waiting for start
// S_RUN   | in_ready high, accepting samples until n_samples are taken
// S_DRAIN | fixed 2-cycle wait so the last sample reaches the totals
// S_DONE  | totals final and stable until the next start
module err_metric_accum #(
  parameter int W     = 16,
  parameter int CNT_W = 32,
  parameter int SUM_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     exact,
  input  logic [W-1:0]     apprx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [SUM_W-1:0] sum_ed,
  output logic [SUM_W-1:0] sum_ed_abs,
  output logic [W-1:0]     max_ed
);

  localparam logic [1:0] DRAIN_LAST = 2'd1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] n_lat;
  logic [1:0]       drain_cnt;
  logic             start_acc;
  logic             accept;
  logic             last_accept;

  logic [W:0]       diff_w;
  logic [W:0]       diff_neg;
  logic [W-1:0]     abs_w;

  logic             s1_valid;
  logic [W:0]       s1_d;
  logic [W-1:0]     s1_a;
  logic             s1_ne;

  assign start_acc   = start && (state == S_IDLE || state == S_DONE);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && ((sample_count + CNT_W'(1)) == n_lat);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        done = (state == S_DONE);
        if (start) state_nxt = (n_samples != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (last_accept) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == '0) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Run length latch, sample counter and drain down-counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_lat        <= '0;
      sample_count <= '0;
      drain_cnt    <= '0;
    end else begin
      if (start_acc) begin
        n_lat        <= n_samples;
        sample_count <= '0;
      end else if (accept) begin
        sample_count <= sample_count + CNT_W'(1);
      end
      if (last_accept)
        drain_cnt <= DRAIN_LAST;
      else if (state == S_DRAIN && drain_cnt != '0)
        drain_cnt <= drain_cnt - 2'd1;
    end
  end

  // Error distance of the incoming pair; the magnitude always fits W bits.
  always_comb begin
    diff_w   = {1'b0, exact} - {1'b0, apprx};
    diff_neg = -diff_w;
    abs_w    = diff_w[W] ? diff_neg[W-1:0] : diff_w[W-1:0];
  end

  // Stage 1: register distance terms of each accepted sample.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      s1_valid <= 1'b0;
      s1_d     <= '0;
      s1_a     <= '0;
      s1_ne    <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_d  <= diff_w;
        s1_a  <= abs_w;
        s1_ne <= (exact != apprx);
      end
    end
  end

  // Stage 2: fold stage-1 terms into the run totals.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      err_count  <= '0;
      sum_ed     <= '0;
      sum_ed_abs <= '0;
      max_ed     <= '0;
    end else if (s1_valid) begin
      err_count  <= err_count + {{(CNT_W-1){1'b0}}, s1_ne};
      sum_ed     <= sum_ed + {{(SUM_W-W-1){s1_d[W]}}, s1_d};
      sum_ed_abs <= sum_ed_abs + {{(SUM_W-W){1'b0}}, s1_a};
      if (s1_a > max_ed) max_ed <= s1_a;
    end
  end

endmodule
